// File: rtl/status_seg_decoder.sv
// Fourteen-segment status monitor: registers the display pattern, decodes it to a
// status code behind a stability filter, and tracks alarm, entry counters and invalid.
module status_seg_decoder #(
  parameter int unsigned STABLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [14:0]      fourteen_seg_i,
  input  logic             alarm_ack_i,
  output logic [2:0]       status_o,
  output logic             status_changed_o,
  output logic             invalid_o,
  output logic             alarm_o,
  output logic [CNT_W-1:0] too_warm_cnt_o,
  output logic [CNT_W-1:0] too_cold_cnt_o
);

  localparam int unsigned SEG_W  = 15;
  localparam int unsigned CODE_W = 3;
  localparam int unsigned STB_W  = 4;

  localparam logic [STB_W-1:0] STB_MAX = STB_W'(STABLE_CYCLES - 1);

  localparam logic [SEG_W-1:0] PAT_RESET    = 15'h0000;
  localparam logic [SEG_W-1:0] PAT_OKAY     = 15'h003F;
  localparam logic [SEG_W-1:0] PAT_WARM     = 15'h0036;
  localparam logic [SEG_W-1:0] PAT_COLD     = 15'h0039;
  localparam logic [SEG_W-1:0] PAT_TOO_WARM = 15'h4036;
  localparam logic [SEG_W-1:0] PAT_TOO_COLD = 15'h4039;

  localparam logic [CODE_W-1:0] CODE_RESET    = 3'd0;
  localparam logic [CODE_W-1:0] CODE_OKAY     = 3'd1;
  localparam logic [CODE_W-1:0] CODE_WARM     = 3'd2;
  localparam logic [CODE_W-1:0] CODE_COLD     = 3'd3;
  localparam logic [CODE_W-1:0] CODE_TOO_WARM = 3'd4;
  localparam logic [CODE_W-1:0] CODE_TOO_COLD = 3'd5;
  localparam logic [CODE_W-1:0] CODE_INVALID  = 3'd7;

  logic [SEG_W-1:0]  seg_q;
  logic [CODE_W-1:0] prev_cand_q;
  logic [STB_W-1:0]  stb_cnt_q;

  logic [CODE_W-1:0] cand_c;
  logic [STB_W-1:0]  stb_cnt_c;
  logic              stable_c;
  logic              valid_accept_c;
  logic              change_c;
  logic              invalid_hit_c;
  logic              warm_entry_c;
  logic              cold_entry_c;

  logic [CODE_W-1:0] status_d;
  logic              changed_d;
  logic              invalid_d;
  logic              alarm_d;
  logic [CNT_W-1:0]  warm_cnt_d;
  logic [CNT_W-1:0]  cold_cnt_d;

  // Pattern-to-code table; anything unrecognised becomes an invalid candidate.
  always_comb begin
    cand_c = CODE_INVALID;
    case (seg_q)
      PAT_RESET:    cand_c = CODE_RESET;
      PAT_OKAY:     cand_c = CODE_OKAY;
      PAT_WARM:     cand_c = CODE_WARM;
      PAT_COLD:     cand_c = CODE_COLD;
      PAT_TOO_WARM: cand_c = CODE_TOO_WARM;
      PAT_TOO_COLD: cand_c = CODE_TOO_COLD;
      default:      cand_c = CODE_INVALID;
    endcase
  end

  // Stability filter: acceptance looks at the count this edge will store, which
  // gives a held pattern exactly STABLE_CYCLES edges of latency to status_o.
  always_comb begin
    stb_cnt_c = '0;
    if (cand_c == prev_cand_q) begin
      stb_cnt_c = (stb_cnt_q >= STB_MAX) ? STB_MAX : stb_cnt_q + STB_W'(1);
    end
    stable_c       = (stb_cnt_c == STB_MAX);
    valid_accept_c = stable_c && (cand_c != CODE_INVALID);
    invalid_hit_c  = stable_c && (cand_c == CODE_INVALID);
    change_c       = valid_accept_c && (cand_c != status_o);
    warm_entry_c   = change_c && (cand_c == CODE_TOO_WARM);
    cold_entry_c   = change_c && (cand_c == CODE_TOO_COLD);
  end

  // Next values for the status, flag and counter registers.
  always_comb begin
    status_d   = status_o;
    changed_d  = change_c;
    invalid_d  = invalid_o;
    alarm_d    = alarm_o;
    warm_cnt_d = too_warm_cnt_o;
    cold_cnt_d = too_cold_cnt_o;

    if (change_c) begin
      status_d = cand_c;
    end

    if (invalid_hit_c) begin
      invalid_d = 1'b1;
    end else if (valid_accept_c) begin
      invalid_d = 1'b0;
    end

    // A new TOO_* entry outranks an acknowledge in the same cycle.
    if (warm_entry_c || cold_entry_c) begin
      alarm_d = 1'b1;
    end else if (alarm_ack_i) begin
      alarm_d = 1'b0;
    end

    if (warm_entry_c && (too_warm_cnt_o != {CNT_W{1'b1}})) begin
      warm_cnt_d = too_warm_cnt_o + CNT_W'(1);
    end
    if (cold_entry_c && (too_cold_cnt_o != {CNT_W{1'b1}})) begin
      cold_cnt_d = too_cold_cnt_o + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seg_q            <= PAT_RESET;
      prev_cand_q      <= CODE_RESET;
      stb_cnt_q        <= '0;
      status_o         <= CODE_RESET;
      status_changed_o <= 1'b0;
      invalid_o        <= 1'b0;
      alarm_o          <= 1'b0;
      too_warm_cnt_o   <= '0;
      too_cold_cnt_o   <= '0;
    end else begin
      seg_q            <= fourteen_seg_i;
      prev_cand_q      <= cand_c;
      stb_cnt_q        <= stb_cnt_c;
      status_o         <= status_d;
      status_changed_o <= changed_d;
      invalid_o        <= invalid_d;
      alarm_o          <= alarm_d;
      too_warm_cnt_o   <= warm_cnt_d;
      too_cold_cnt_o   <= cold_cnt_d;
    end
  end

endmodule

// File: doc/status_seg_decoder.md
Name: status_seg_decoder

Overview:
Monitor and decoder on the output side of the status display. It samples the 15-bit fourteen-segment pattern driven by seq_display and decodes it back into a 3-bit status code. A stability filter rejects glitches. The block also keeps a sticky alarm, saturating TOO_WARM/TOO_COLD entry counters and an invalid-pattern flag, for use as a scoreboard/checker and as an on-chip status readback.

Parameters:
STABLE_CYCLES, 2, consecutive identical samples needed before a new status is accepted (legal range 1..15)
CNT_W, 8, width of the entry counters

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
fourteen_seg_i  in  15  segment pattern from the display driver
alarm_ack_i  in  1  clears alarm_o
status_o  out  3  accepted status code
status_changed_o  out  1  one-cycle pulse when status_o changes
invalid_o  out  1  an unknown pattern has been stable STABLE_CYCLES samples
alarm_o  out  1  sticky, set on entry to a TOO_* status
too_warm_cnt_o  out  CNT_W  saturating count of TOO_WARM entries
too_cold_cnt_o  out  CNT_W  saturating count of TOO_COLD entries

Behaviour:
- Fixed pattern-to-code table:
  - RESET 15'h0000 -> 0
  - OKAY 15'h003F -> 1
  - WARM 15'h0036 -> 2
  - COLD 15'h0039 -> 3
  - TOO_WARM 15'h4036 -> 4
  - TOO_COLD 15'h4039 -> 5
  - any other pattern -> candidate INVALID (internal code 7; never driven on status_o)
- Reset (rst_i high at an edge):
  - status_o=0, status_changed_o=0, invalid_o=0, alarm_o=0, both counters=0.
  - Input register and stability state cleared. Sampled pattern reset to 15'h0000; stable count reset to 0.
  - Reset wins over every other event in the same cycle.
- Pipeline:
  - fourteen_seg_i is registered every edge into seg_q.
  - The candidate code is decoded combinationally from seg_q.
- Stability counter:
  - Candidate equals the previous candidate: count increments, saturating at STABLE_CYCLES-1.
  - Candidate differs: count resets to 0.
- Acceptance: count == STABLE_CYCLES-1 with candidate != INVALID and candidate != status_o:
  - status_o <= candidate at the next edge, and status_changed_o pulses high for exactly that cycle.
- Latency: a pattern present before edge E and held is visible on status_o after edge E+STABLE_CYCLES.
- A stable pattern equal to the current status produces no pulse.
- A shorter glitch is ignored, and the count restarts.
- INVALID stable for the acceptance condition:
  - invalid_o goes high and status_o holds its value.
  - invalid_o stays high until a valid pattern is accepted or reset.
  - Acceptance of any valid code, including the same code as status_o, clears invalid_o; no pulse if the code is unchanged.
- Alarm:
  - Set on acceptance of code 4 or 5; cleared by alarm_ack_i.
  - Set and ack in the same cycle: set wins.
- Counters:
  - too_warm_cnt_o / too_cold_cnt_o increment by 1 on each acceptance of code 4 / 5.
  - They hold at 2^CNT_W-1.
- All outputs are registered; there is no combinational input-to-output path.

Test Plan:
1. Reset, then 15'h003F held for 4 cycles -> status_o=1 after the 3rd edge, single status_changed_o pulse; invalid_o=0, alarm_o=0.
2. OKAY stable, then 15'h0036 for 1 cycle, then back to OKAY -> no status change, no pulse; then WARM held -> status_o=2 with one pulse.
3. 15'h4039 held -> status_o=5, alarm_o=1, too_cold_cnt_o=1. Then 15'h0000 held -> status_o=0 while alarm_o stays 1. Pulse alarm_alarm_ack_i -> alarm_o=0.
4. 15'h1234 held 3 cycles -> invalid_o=1 with status_o unchanged. Then 15'h0039 held -> status_o=3, invalid_o=0.
5. CNT_W=2: alternate TOO_WARM and OKAY 5 times -> too_warm_cnt_o saturates at 3. Also: alarm_ack_i asserted in the same cycle as a new TOO_WARM acceptance -> alarm_o=1.
6. rst_i asserted mid-acceptance (stable count at 1, STABLE_CYCLES=2) -> all outputs 0 next cycle, no pulse; a pattern held from release is accepted only after STABLE_CYCLES+1 edges.
